inst_prefetch_buffer: RTL and testbench
=======================================

# inst_prefetch_buffer

Fetch-side buffer between the program counter and the instruction register. It issues word fetches to a variable-latency instruction memory and queues the returned instructions with their PC+4 values in a small FIFO. It presents the head entry to the IR/ID stage, and it flushes and re-steers on a taken branch or jump. It replaces the direct PC → instruction-memory path with a decoupled one, so memory wait states no longer stall decode directly.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- Clock  input  1  clock; all state changes on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- redirect  input  1  taken branch/jump from ID; flushes the buffer.
- redirect_pc  input  32  new fetch address (bpc/jpc), sampled when redirect=1.
- wpc  input  1  downstream accept; the head is consumed when if_valid & wpc.
- imem_req  output  1  fetch request.
- imem_addr  output  32  word address of the outstanding request.
- imem_ack  input  1  memory returns imem_rdata this cycle; completes the request.
- imem_rdata  input  32  fetched instruction.
- if_valid  output  1  head entry valid.
- IF_Inst  output  32  head instruction.
- if_pc4  output  32  head PC+4.
- fifo_count  output  $clog2(DEPTH)+1  occupancy.

## Operation
- fetch_pc register: reset value RESET_PC; increments by 4 on each accepted ack; loads redirect_pc on redirect.
- The FSM has three states:
  - IDLE: no request outstanding.
  - BUSY: imem_req=1, imem_addr=fetch_pc.
  - DROP: imem_req=1 and the stale address is held; the returning data is discarded.
- imem_req and imem_addr stay stable from assertion until imem_ack. A request is never withdrawn.
- At most one request is outstanding.
- Room condition: (fifo_count − pop) < DEPTH, where pop = if_valid & wpc.
- IDLE:
  - redirect → load fetch_pc, stay IDLE.
  - Else if room → BUSY.
- BUSY:
  - ack & !redirect → push {imem_rdata, fetch_pc+4}, fetch_pc += 4. Next state is BUSY if room remains after the push, else IDLE.
  - redirect & ack → discard data, load fetch_pc, go to IDLE.
  - redirect & !ack → DROP.
- DROP:
  - ack → discard, go to IDLE.
  - A further redirect reloads fetch_pc and stays in DROP.
- Redirect empties the FIFO on the same edge: if_valid=0 next cycle, and any pop that cycle is ignored.
- Head outputs are read combinationally from FIFO storage. When the FIFO is empty, IF_Inst and if_pc4 are 0.
- Push and pop in the same cycle leave the count unchanged. Pop while empty is a no-op. Push while full cannot occur, because of the room rule.
- Addresses wrap modulo 2^32. fetch_pc[1:0] is forced to 0.

## Timing
- Reset values:
  - state IDLE, fetch_pc = RESET_PC, FIFO empty.
  - imem_req=0, if_valid=0, IF_Inst=0, if_pc4=0, fifo_count=0.
- A reset asserted mid-request abandons the request. The memory must tolerate imem_req dropping.
- First imem_req arrives one cycle after Resetn deasserts.
- Zero-wait memory (ack the cycle the request is seen):
  - Sustained throughput is one instruction per cycle.
  - Request-to-if_valid latency is one cycle.
- Redirect at edge N:
  - if_valid=0 during N+1.
  - With no request outstanding, the new-target request is issued at N+2. With a DROP pending, it is issued two cycles after the stale ack.
- Full FIFO with wpc=0: imem_req stays 0 once the request in flight completes.

## Configuration
- PREFETCH_STATS_EN defined:
  - Adds output drop_count[15:0], incremented on every discarded ack.
  - Adds output stall_count[15:0], incremented each cycle with if_valid=0 and Resetn high.
  - Both counters saturate at 16'hFFFF and reset to 0.
- PREFETCH_STATS_EN undefined: the ports and logic are absent.

## Structure
- Shared package ppcpu_pkg:
  - pf_state_t enum (PF_IDLE, PF_BUSY, PF_DROP).
  - PF_ENTRY_W = 64.
  - Default RESET_PC constant.
- Sub-module pf_fifo:
  - Parameterised DEPTH × 64-bit circular buffer with push, pop, flush and count.
  - Pointers are one bit wider than the index to distinguish full from empty.
- The top level holds the FSM, fetch_pc and the handshake.

## Test plan
- Reset, memory with zero wait states, wpc=1 → imem_addr sequence 0,4,8,…; IF_Inst follows memory contents; if_pc4 = 4,8,12,….
- wpc=0 held, DEPTH=4 → exactly 4 pushes, fifo_count=4, imem_req=0. Then set wpc=1 for one cycle → one new request is issued and the count returns to 4.
- Memory with 3 wait states, redirect to 0x100 in the second cycle of a request to 0x8 → ack data for 0x8 is discarded, the FIFO stays empty, and the next imem_addr is 0x100.
- Redirect coincident with imem_ack → data dropped; the next request goes to redirect_pc; if_valid=0 for the following cycle.
- fetch_pc = 0xFFFF_FFFC → next fetch address is 0x0 and if_pc4=0x0.
- Resetn pulsed low during BUSY with FIFO count 2 → all outputs return to reset values immediately and the first post-reset fetch is to RESET_PC. With PREFETCH_STATS_EN, drop_count is 0 and then counts each discarded ack.

Source files
------------

// File: rtl/ppcpu_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package ppcpu_pkg;

    // Fetch FSM: no request, live request, or stale request whose data is discarded.
    typedef enum logic [1:0] {
        PF_IDLE = 2'd0,
        PF_BUSY = 2'd1,
        PF_DROP = 2'd2
    } pf_state_t;

    // One buffered entry: {instruction, pc+4}.
    localparam int PF_ENTRY_W = 64;

    // Default first fetch address after reset.
    localparam logic [31:0] PF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_prefetch_buffer_if.sv
// Instruction-memory fetch port of the prefetch buffer.
//
// Handshake: imem_req is the request valid and imem_ack completes it. Once
// imem_req rises, imem_req and imem_addr hold steady until the cycle imem_ack
// is high; imem_rdata is sampled in that same cycle. A request is never
// withdrawn except by reset, and at most one is outstanding.
interface inst_prefetch_buffer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pf_fifo.sv
// DEPTH x 64-bit circular buffer with push, pop, flush and occupancy.
// Pointers carry one extra bit so full and empty are distinguishable.
module pf_fifo
    import ppcpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [PF_ENTRY_W-1:0]   wdata,
    output logic [PF_ENTRY_W-1:0]   rdata,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [PF_ENTRY_W-1:0] mem [DEPTH];
    logic                  empty;
    logic                  do_pop;

    assign count  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign do_pop = pop & ~empty;
    assign rdata  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; flush empties the buffer and overrides push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // Entry storage; contents are only visible through a valid head.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/inst_prefetch_buffer.sv
// Decoupled fetch buffer: issues word fetches to a variable-latency memory,
// queues {instruction, pc+4}, presents the head to decode, and flushes and
// re-steers on redirect. Optional PREFETCH_STATS_EN adds drop/stall counters.
module inst_prefetch_buffer
    import ppcpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = PF_RESET_PC
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    input  logic                   wpc,
    inst_prefetch_buffer_if.master imem,
    output logic                   if_valid,
    output logic [31:0]            IF_Inst,
    output logic [31:0]            if_pc4,
    output logic [$clog2(DEPTH):0] fifo_count,
`ifdef PREFETCH_STATS_EN
    output logic [15:0]            drop_count,
    output logic [15:0]            stall_count,
`endif
    output pf_state_t              dbg_state
);
    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    pf_state_t   state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] stale_pc, stale_pc_n;
    logic        push;
    logic        pop_raw;
    logic [CW-1:0] after_pop;
    logic        room;
    logic        room_after_push;
    logic [PF_ENTRY_W-1:0] head;

    assign pop_raw         = if_valid & wpc;
    assign after_pop       = fifo_count - CW'(pop_raw);
    assign room            = after_pop < DEPTH_C;
    assign room_after_push = after_pop < (DEPTH_C - CW'(1));

    assign imem.imem_req  = (state != PF_IDLE);
    assign imem.imem_addr = (state == PF_DROP) ? stale_pc : fetch_pc;
    assign if_valid       = (fifo_count != '0);
    assign IF_Inst        = head[63:32];
    assign if_pc4         = head[31:0];
    assign dbg_state      = state;

    pf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (Clock),
        .rst_n (Resetn),
        .push  (push),
        .pop   (pop_raw & ~redirect),
        .flush (redirect),
        .wdata ({imem.imem_rdata, fetch_pc + 32'd4}),
        .rdata (head),
        .count (fifo_count)
    );

    // FSM state, fetch address and held stale address.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= PF_IDLE;
            fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
            stale_pc <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            stale_pc <= stale_pc_n;
        end
    end

    // Next state, fetch address and push decision.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        stale_pc_n = stale_pc;
        push       = 1'b0;
        if (redirect) fetch_pc_n = redirect_pc & 32'hFFFF_FFFC;
        unique case (state)
            PF_IDLE: begin
                if (!redirect && room) state_n = PF_BUSY;
            end
            PF_BUSY: begin
                if (redirect) begin
                    if (imem.imem_ack) begin
                        state_n = PF_IDLE;
                    end else begin
                        // Keep presenting the old address until memory answers.
                        state_n    = PF_DROP;
                        stale_pc_n = fetch_pc;
                    end
                end else if (imem.imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc + 32'd4;
                    state_n    = room_after_push ? PF_BUSY : PF_IDLE;
                end
            end
            PF_DROP: begin
                if (imem.imem_ack) state_n = PF_IDLE;
            end
            default: state_n = PF_IDLE;
        endcase
    end

`ifdef PREFETCH_STATS_EN
    logic drop_ack;
    assign drop_ack = imem.imem_ack &
                      (((state == PF_BUSY) & redirect) | (state == PF_DROP));

    // Saturating counters of discarded returns and empty-head cycles.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            drop_count  <= '0;
            stall_count <= '0;
        end else begin
            if (drop_ack && drop_count != 16'hFFFF)  drop_count  <= drop_count + 16'd1;
            if (!if_valid && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Self-checking bench for inst_prefetch_buffer: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_inst_prefetch_buffer;
  import ppcpu_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic Clock;
  logic Resetn;
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          wpc;
  logic          if_valid;
  logic [31:0]   IF_Inst;
  logic [31:0]   if_pc4;
  logic [CW-1:0] fifo_count;
  pf_state_t     dbg_state;
`ifdef PREFETCH_STATS_EN
  logic [15:0]   drop_count;
  logic [15:0]   stall_count;
`endif

  inst_prefetch_buffer_if bus();

  inst_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .wpc         (wpc),
    .imem        (bus.master),
    .if_valid    (if_valid),
    .IF_Inst     (IF_Inst),
    .if_pc4      (if_pc4),
    .fifo_count  (fifo_count),
`ifdef PREFETCH_STATS_EN
    .drop_count  (drop_count),
    .stall_count (stall_count),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_stale_addr;
  bit          m_stale;
  int          m_drops;
  int          m_stalls;
  int          n_kept;
  int          wcnt;
  int          wait_states;
  bit          rand_wait;
  bit          prev_hold;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc         = RESET_PC & 32'hFFFF_FFFC;
    m_stale      = 1'b0;
    m_stale_addr = '0;
    m_drops      = 0;
    m_stalls     = 0;
    wcnt         = 0;
    prev_hold    = 1'b0;
  endtask

  // Compare every observable output with the model.
  task automatic check_outputs();
    logic [63:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 64'd0;
    chk("if_valid", if_valid, exp_q.size() != 0);
    chk("fifo_count", fifo_count, exp_q.size());
    chk("IF_Inst", IF_Inst, head[63:32]);
    chk("if_pc4", if_pc4, head[31:0]);
    if (bus.imem_req) chk("imem_addr", bus.imem_addr, m_stale ? m_stale_addr : m_pc);
`ifdef PREFETCH_STATS_EN
    chk("drop_count", drop_count, m_drops);
    chk("stall_count", stall_count, m_stalls);
`endif
  endtask

  // ---------------- driver: one clock cycle with memory response ----------------
  // Called at a negedge with redirect/wpc/redirect_pc already driven.
  task automatic tick();
    logic        req_c, ack_c, red_c, wpc_c;
    logic [31:0] rpc_c;
    int          size0;
    req_c = bus.imem_req;
    ack_c = req_c && (wcnt >= wait_states);
    bus.imem_ack   = ack_c;
    bus.imem_rdata = ack_c ? mem_word(bus.imem_addr) : $urandom;
    red_c = redirect;
    wpc_c = wpc;
    rpc_c = redirect_pc;
    check_outputs();
    if (prev_hold) chk("req_held", req_c, 1'b1);
    @(posedge Clock);
    size0 = exp_q.size();
    if (size0 == 0 && m_stalls < 65535) m_stalls++;
    if (size0 != 0 && wpc_c && !red_c) void'(exp_q.pop_front());
    if (ack_c) begin
      if (red_c || m_stale) begin
        m_stale = 1'b0;
        if (m_drops < 65535) m_drops++;
      end else begin
        exp_q.push_back({mem_word(m_pc), m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
        n_kept++;
      end
    end
    if (red_c) begin
      exp_q.delete();
      if (req_c && !ack_c && !m_stale) begin
        m_stale      = 1'b1;
        m_stale_addr = m_pc;
      end
      m_pc = rpc_c & 32'hFFFF_FFFC;
    end
    prev_hold = req_c && !ack_c;
    wcnt = prev_hold ? wcnt + 1 : 0;
    if (rand_wait && !prev_hold) wait_states = $urandom_range(0, 3);
    @(negedge Clock);
  endtask

  // Asynchronous reset starting at a negedge; ends with the first fetch issued.
  task automatic do_reset();
    Resetn       = 1'b0;
    redirect     = 1'b0;
    wpc          = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    chk("rst_imem_req", bus.imem_req, 1'b0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_IF_Inst", IF_Inst, 32'd0);
    chk("rst_if_pc4", if_pc4, 32'd0);
    chk("rst_fifo_count", fifo_count, 0);
`ifdef PREFETCH_STATS_EN
    chk("rst_drop_count", drop_count, 0);
    chk("rst_stall_count", stall_count, 0);
`endif
    repeat (2) @(negedge Clock);
    model_reset();
    Resetn = 1'b1;
    chk("post_rst_req_low", bus.imem_req, 1'b0);
    tick();
    chk("first_req", bus.imem_req, 1'b1);
    chk("first_addr", bus.imem_addr, RESET_PC);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int kept0;
    int guard;
    Resetn       = 1'b1;
    redirect     = 1'b0;
    redirect_pc  = '0;
    wpc          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    rand_wait    = 1'b0;
    wait_states  = 0;
    n_kept       = 0;
    model_reset();
    @(negedge Clock);

    // Zero-wait streaming with wpc=1: one-cycle latency, one per cycle.
    do_reset();
    wpc = 1'b1;
    tick();
    chk("lat_valid", if_valid, 1'b1);
    chk("lat_inst", IF_Inst, mem_word(32'h0));
    chk("lat_pc4", if_pc4, 32'h4);
    kept0 = n_kept;
    repeat (12) tick();
    chk("throughput", n_kept - kept0, 12);

    // Hold wpc=0 until full, then release for one cycle.
    wpc = 1'b0;
    repeat (10) tick();
    chk("full_count", fifo_count, DEPTH);
    chk("full_req", bus.imem_req, 1'b0);
    kept0 = n_kept;
    wpc = 1'b1;
    tick();
    wpc = 1'b0;
    repeat (5) tick();
    chk("refill_one", n_kept - kept0, 1);
    chk("refill_count", fifo_count, DEPTH);
    chk("refill_req", bus.imem_req, 1'b0);

    // Three wait states; redirect in the second cycle of the request to 0x8.
    wait_states = 3;
    do_reset();
    wpc = 1'b1;
    guard = 0;
    while (!(bus.imem_req && bus.imem_addr == 32'h8) && guard < 40) begin
      tick();
      guard++;
    end
    chk("wait_req8_timeout", guard < 40, 1'b1);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("drop_valid", if_valid, 1'b0);
    chk("drop_hold_req", bus.imem_req, 1'b1);
    chk("drop_hold_addr", bus.imem_addr, 32'h8);
    guard = 0;
    while (bus.imem_req && guard < 10) begin
      tick();
      guard++;
    end
    chk("stale_ack_timeout", guard < 10, 1'b1);
    chk("drop_empty", fifo_count, 0);
    tick();
    chk("retarget_req", bus.imem_req, 1'b1);
    chk("retarget_addr", bus.imem_addr, 32'h100);

    // Zero-wait redirect coincident with imem_ack.
    wait_states = 0;
    repeat (6) tick();
    chk("coinc_pre_req", bus.imem_req, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("coinc_valid", if_valid, 1'b0);
    chk("coinc_idle", bus.imem_req, 1'b0);
    tick();
    chk("coinc_req", bus.imem_req, 1'b1);
    chk("coinc_addr", bus.imem_addr, 32'h200);
    tick();
    chk("coinc_pc4", if_pc4, 32'h204);

    // Address wrap at the top of the address space; low bits forced to 0.
    wpc         = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    tick();
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_inst", IF_Inst, mem_word(32'hFFFF_FFFC));
    chk("wrap_pc4", if_pc4, 32'h0);
    chk("wrap_next_addr", bus.imem_addr, 32'h0);

    // Reset pulsed during BUSY with two entries buffered.
    wait_states = 3;
    do_reset();
    guard = 0;
    while (!(fifo_count == CW'(2) && bus.imem_req) && guard < 40) begin
      tick();
      guard++;
    end
    chk("count2_timeout", guard < 40, 1'b1);
    do_reset();

    // Randomized traffic with random wait states, redirects and back-pressure.
    rand_wait = 1'b1;
    for (int i = 0; i < 600; i++) begin
      wpc         = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : $urandom;
      tick();
    end
    redirect = 1'b0;
    wpc      = 1'b0;
    repeat (4) tick();

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
